// File: rtl/button_level_conditioner.sv
// Push-button conditioner: synchronise, debounce, and emit edge and long-press pulses.
// Ports: clk, rst (async active-low), btn_raw in; LEVEL, rise_pulse, fall_pulse, long_pulse out.
module button_level_conditioner #(
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 16,
    parameter int LONG_CYCLES = 20,
    parameter int HOLD_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic LEVEL,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              r_s1;
    logic              r_sq;
    state_t            r_state;
    logic [CNT_W-1:0]  r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_fired;

    logic w_level_hi;
    logic w_fall_now;

    // Long-press timing runs in both LEVEL=1 states so a bounce
    // into RELEASE_WAIT does not restart the hold count.
    assign w_level_hi = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    assign w_fall_now = (r_state == RELEASE_WAIT) && !r_sq &&
                        (r_db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_sq <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_sq <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_fired    <= 1'b0;
            LEVEL      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            long_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sq) begin
                        r_state  <= PRESS_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sq) begin
                        r_state <= IDLE;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state    <= PRESSED;
                        LEVEL      <= 1'b1;
                        rise_pulse <= 1'b1;
                        r_hold_cnt <= '0;
                        r_fired    <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!r_sq) begin
                        r_state  <= RELEASE_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sq) begin
                        r_state <= PRESSED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state    <= IDLE;
                        LEVEL      <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    LEVEL   <= 1'b0;
                end
            endcase

            // A fall on the expiry edge suppresses the long pulse.
            if (w_level_hi && !w_fall_now && !r_fired) begin
                if (r_hold_cnt == LONG_LAST) begin
                    long_pulse <= 1'b1;
                    r_fired    <= 1'b1;
                end else begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

endmodule
